// File: rtl/pc_call_stack_if.sv
// Request/response bundle between a sequencer and the pc_call_stack
// program counter with its hardware return stack.
interface pc_call_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    logic                     load;
    logic                     inc;
    logic                     call;
    logic                     ret;
    logic [WIDTH-1:0]         addr_in;
    logic [WIDTH-1:0]         pc_out;
    logic [WIDTH-1:0]         top_out;
    logic [$clog2(DEPTH):0]   depth_out;
    logic                     full;
    logic                     empty;
    logic                     err;

    modport master (
        output load, inc, call, ret, addr_in,
        input  pc_out, top_out, depth_out, full, empty, err
    );

    modport slave (
        input  load, inc, call, ret, addr_in,
        output pc_out, top_out, depth_out, full, empty, err
    );
endinterface

// File: rtl/pc_call_stack.sv
// Registered program counter with a LIFO return stack. One request per edge,
// priority rst > ret > call > load > inc; overflow/underflow set a sticky err.
module pc_call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    pc_call_stack_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_ONE  = (PW+1)'(1);
    localparam logic [PW:0] DEPTH_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [PW:0]      depth;
    logic [PW:0]      depth_nxt;
    logic [PW:0]      depth_dec;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic             err;
    logic             err_nxt;
    logic             push;
    logic             is_full;
    logic             is_empty;
    logic [WIDTH-1:0] top;

    assign pc_inc    = pc + WIDTH'(1);
    assign depth_dec = depth - DEPTH_ONE;
    assign top_idx   = depth_dec[PW-1:0];
    assign wr_idx    = depth[PW-1:0];
    assign is_full   = (depth == DEPTH_FULL);
    assign is_empty  = (depth == '0);
    assign top       = is_empty ? '0 : stack[top_idx];

    always_comb begin
        pc_nxt    = pc;
        depth_nxt = depth;
        err_nxt   = err;
        push      = 1'b0;
        if (bus.ret) begin
            if (is_empty) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt    = top;
                depth_nxt = depth_dec;
            end
        end else if (bus.call) begin
            if (is_full) begin
                err_nxt = 1'b1;
            end else begin
                push      = 1'b1;
                pc_nxt    = bus.addr_in;
                depth_nxt = depth + DEPTH_ONE;
            end
        end else if (bus.load) begin
            pc_nxt = bus.addr_in;
        end else if (bus.inc) begin
            pc_nxt = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            depth <= '0;
            err   <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            depth <= depth_nxt;
            err   <= err_nxt;
        end
    end

    // Storage is never cleared; depth alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack[wr_idx] <= pc_inc;
        end
    end

    assign bus.pc_out    = pc;
    assign bus.top_out   = top;
    assign bus.depth_out = depth;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.err       = err;
endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack (WIDTH=16, DEPTH=4): each step queues its
// expected outputs, then pops and checks them one cycle after the edge.
module tb_pc_call_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [15:0] top;
        logic [2:0]  depth;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    pc_call_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    pc_call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic rt, input logic c,
                        input logic l, input logic i, input logic [15:0] addr,
                        input logic [15:0] e_pc, input logic [15:0] e_top,
                        input logic [2:0] e_depth, input logic e_err);
        exp_t e;
        exp_t g;
        rst         = r;
        bus.ret     = rt;
        bus.call    = c;
        bus.load    = l;
        bus.inc     = i;
        bus.addr_in = addr;
        e.tag = tag; e.pc = e_pc; e.top = e_top; e.depth = e_depth; e.err = e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".scoreboard"}, 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk({g.tag, ".pc"},    32'(bus.pc_out),    32'(g.pc));
            chk({g.tag, ".top"},   32'(bus.top_out),   32'(g.top));
            chk({g.tag, ".depth"}, 32'(bus.depth_out), 32'(g.depth));
            chk({g.tag, ".full"},  32'(bus.full),      32'(g.depth == 3'd4));
            chk({g.tag, ".empty"}, 32'(bus.empty),     32'(g.depth == 3'd0));
            chk({g.tag, ".err"},   32'(bus.err),       32'(g.err));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.ret = 1'b0; bus.call = 1'b0; bus.load = 1'b0; bus.inc = 1'b0;
        bus.addr_in = '0;
        @(posedge clk);
        #1;

        //    tag          rst ret call load inc addr      pc       top      dep err
        step("rst0",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
        step("inc1",       0, 0, 0, 0, 1, 16'h0000, 16'h0001, 16'h0000, 3'd0, 0);
        step("inc2",       0, 0, 0, 0, 1, 16'h0000, 16'h0002, 16'h0000, 3'd0, 0);
        step("inc3",       0, 0, 0, 0, 1, 16'h0000, 16'h0003, 16'h0000, 3'd0, 0);

        step("ld10",       0, 0, 0, 1, 0, 16'h0010, 16'h0010, 16'h0000, 3'd0, 0);
        step("call100",    0, 0, 1, 0, 0, 16'h0100, 16'h0100, 16'h0011, 3'd1, 0);
        step("ret11",      0, 1, 0, 0, 0, 16'h0000, 16'h0011, 16'h0000, 3'd0, 0);

        step("rst1",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
        step("call1000",   0, 0, 1, 0, 0, 16'h1000, 16'h1000, 16'h0001, 3'd1, 0);
        step("call2000",   0, 0, 1, 0, 0, 16'h2000, 16'h2000, 16'h1001, 3'd2, 0);
        step("call3000",   0, 0, 1, 0, 0, 16'h3000, 16'h3000, 16'h2001, 3'd3, 0);
        step("call4000",   0, 0, 1, 0, 0, 16'h4000, 16'h4000, 16'h3001, 3'd4, 0);
        step("call_ovf",   0, 0, 1, 0, 0, 16'h5000, 16'h4000, 16'h3001, 3'd4, 1);
        step("ret3001",    0, 1, 0, 0, 0, 16'h0000, 16'h3001, 16'h2001, 3'd3, 1);
        step("ret2001",    0, 1, 0, 0, 0, 16'h0000, 16'h2001, 16'h1001, 3'd2, 1);
        step("ret1001",    0, 1, 0, 0, 0, 16'h0000, 16'h1001, 16'h0001, 3'd1, 1);
        step("ret0001",    0, 1, 0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 3'd0, 1);
        step("ret_unf",    0, 1, 0, 0, 0, 16'h0000, 16'h0001, 16'h0000, 3'd0, 1);

        step("rst2",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
        step("ret_unf0",   0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1);
        step("ldAA",       0, 0, 0, 1, 0, 16'h00AA, 16'h00AA, 16'h0000, 3'd0, 1);
        step("rst3",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);

        step("ldFFFF",     0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 3'd0, 0);
        step("inc_wrap",   0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
        step("ldFFFF_b",   0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 3'd0, 0);
        step("call_wrap",  0, 0, 1, 0, 0, 16'h0200, 16'h0200, 16'h0000, 3'd1, 0);

        step("rst4",       1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
        step("ld4F",       0, 0, 0, 1, 0, 16'h004F, 16'h004F, 16'h0000, 3'd0, 0);
        step("call123",    0, 0, 1, 0, 0, 16'h0123, 16'h0123, 16'h0050, 3'd1, 0);
        step("prio_ret",   0, 1, 1, 1, 1, 16'h0777, 16'h0050, 16'h0000, 3'd0, 0);
        step("prio_call",  0, 0, 1, 1, 1, 16'h0300, 16'h0300, 16'h0051, 3'd1, 0);
        step("prio_load",  0, 0, 0, 1, 1, 16'h0400, 16'h0400, 16'h0051, 3'd1, 0);
        step("hold",       0, 0, 0, 0, 0, 16'h0555, 16'h0400, 16'h0051, 3'd1, 0);
        step("rst_all",    1, 1, 1, 1, 1, 16'h0999, 16'h0000, 16'h0000, 3'd0, 0);
        step("ret_post",   0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1);

        rst = 1'b0;
        bus.ret = 1'b0; bus.call = 1'b0; bus.load = 1'b0; bus.inc = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_call_stack.md
PC_CALL_STACK -- requirements
Module: pc_call_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of program counter and stack entries.
REQ-002 SHALL have parameter DEPTH, default 8, number of return-stack entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port load  input  1  jump request: pc <= addr_in.
REQ-006 SHALL have port inc  input  1  increment request: pc <= pc+1.
REQ-007 SHALL have port call  input  1  subroutine call: push pc+1, pc <= addr_in.
REQ-008 SHALL have port ret  input  1  return: pc <= top of stack, pop.
REQ-009 SHALL have port addr_in  input  WIDTH  jump/call target.
REQ-010 SHALL have port pc_out  output  WIDTH  current program counter (registered).
REQ-011 SHALL have port top_out  output  WIDTH  current top-of-stack entry; 0 when empty.
REQ-012 SHALL have port depth_out  output  $clog2(DEPTH)+1  number of valid stack entries.
REQ-013 SHALL have ports full, empty  output  1 each  depth_out==DEPTH / depth_out==0.
REQ-014 SHALL have port err  output  1  sticky stack overflow/underflow flag.

Function
REQ-015 SHALL evaluate requests once per rising edge with fixed priority: rst > ret > call > load > inc > hold.
REQ-016 SHALL apply only the highest-priority asserted request; lower requests that cycle are discarded, not queued.
REQ-017 SHALL make every pc_out change visible one cycle after the requesting edge (latency 1, no combinational path from inputs to pc_out).
REQ-018 SHALL compute pc+1 modulo 2^WIDTH; inc at all-ones wraps pc_out to 0.
REQ-019 call when not full: push (pc+1 mod 2^WIDTH), pc <= addr_in, depth +1.
REQ-020 call when full: no push, pc unchanged, depth unchanged, err <= 1.
REQ-021 ret when not empty: pc <= top entry, pop, depth -1; exposed entry becomes top_out next cycle.
REQ-022 ret when empty: pc unchanged, depth unchanged, err <= 1.
REQ-023 load: pc <= addr_in; stack untouched.
REQ-024 hold (no request): pc, stack, err unchanged.
REQ-025 SHALL derive top_out, depth_out, full, empty combinationally from registered stack state only.
REQ-026 err SHALL remain 1 once set until rst; subsequent legal operations proceed normally while err=1.
REQ-027 Stack SHALL be LIFO; entries below top SHALL be unaffected by push/pop of entries above.

Reset
REQ-028 On rising edge with rst=1: pc_out=0, depth_out=0, empty=1, full=0, top_out=0, err=0, regardless of other inputs.
REQ-029 rst mid-sequence (stack partially filled) SHALL discard all entries; a following ret SHALL underflow.
REQ-030 Stack storage contents need not be cleared; only depth pointer and outputs are defined after reset.

Verification (WIDTH=16, DEPTH=4)
REQ-031 rst, then inc x3 -> pc_out 0,1,2,3 on successive cycles; empty=1, err=0.
REQ-032 pc=0x0010, call addr_in=0x0100 -> pc_out=0x0100, top_out=0x0011, depth_out=1; then ret -> pc_out=0x0011, depth_out=0, empty=1.
REQ-033 Four nested calls from pc 0x0000 to 0x1000,0x2000,0x3000,0x4000 -> full=1, top_out=0x3001; fifth call to 0x5000 -> pc_out stays 0x4000, depth_out=4, err=1; four rets -> pc_out 0x3001,0x2001,0x1001,0x0001.
REQ-034 rst, ret -> pc_out=0, err=1; then load 0x00AA -> pc_out=0x00AA, err stays 1; rst -> err=0.
REQ-035 pc=0xFFFF: inc -> pc_out=0x0000; separately pc=0xFFFF, call 0x0200 -> top_out=0x0000.
REQ-036 Same cycle ret+call+load+inc with depth 1, top 0x0050 -> pc_out=0x0050, depth_out=0; same cycle rst+call -> all reset values of REQ-028.
